decode_stage: RTL and testbench

- Instruction decode / register-read stage of the RV32 core; sits directly upstream of the Exec ALU stage.
- Accepts one fetched instruction per cycle over a valid/ready handshake and decodes the RV32I OP and OP-IMM integer subset.
- Reads the 32x32 register file and presents registered Operand1, Operand2 and Operation to Exec, plus the destination register for writeback.
- Owns the architectural register file; the writeback stage writes it back through a dedicated port.

---
 rtl/rvp_pkg.sv | 36 +++
 rtl/decode_stage_reg_file.sv | 39 +++
 rtl/decode_stage.sv | 142 ++++++++++++++
 tb/tb_decode_stage.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvp_pkg.sv
// Shared definitions for the RV32 pipeline: ALU opcodes, major opcodes,
// funct7 values and the decode-to-exec bundle.
package rvp_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  typedef enum logic [3:0] {
    ALU_ADD     = 4'd0,
    ALU_SUB     = 4'd1,
    ALU_AND     = 4'd2,
    ALU_OR      = 4'd3,
    ALU_XOR     = 4'd4,
    ALU_SLL     = 4'd5,
    ALU_SRL     = 4'd6,
    ALU_SRA     = 4'd7,
    ALU_SLT     = 4'd8,
    ALU_ILLEGAL = 4'd15
  } alu_op_e;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    alu_op_e         op;
    logic [4:0]      rd;
    logic            reg_write;
    logic            illegal;
  } id_ex_t;

endpackage

// File: rtl/decode_stage_reg_file.sv
// Architectural register file: two read ports, one write port,
// x0 hardwired to zero, same-cycle write-through to the read ports.
module reg_file
  import rvp_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);

  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && wa != 5'd0) begin
      regs[wa] <= wd;
    end
  end

  always_comb begin
    rd1 = regs[ra1];
    if (ra1 == 5'd0) rd1 = '0;
    else if (we && wa == ra1) rd1 = wd;
  end

  always_comb begin
    rd2 = regs[ra2];
    if (ra2 == 5'd0) rd2 = '0;
    else if (we && wa == ra2) rd2 = wd;
  end

endmodule

// File: rtl/decode_stage.sv
// Decode / register-read stage for the RV32I OP and OP-IMM subset.
// Single output register with a valid/ready skid-free handshake.
module decode_stage
  import rvp_pkg::*;
(
  input  logic            Clk,
  input  logic            Reset,
  input  logic            InValid,
  output logic            InReady,
  input  logic [31:0]     Instr,
  input  logic            Flush,
  input  logic            WbEn,
  input  logic [4:0]      WbAddr,
  input  logic [XLEN-1:0] WbData,
  output logic            OutValid,
  input  logic            OutReady,
  output logic [XLEN-1:0] Operand1,
  output logic [XLEN-1:0] Operand2,
  output logic [3:0]      Operation,
  output logic [4:0]      Rd,
  output logic            RegWrite,
  output logic            Illegal
);

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            is_op;
  logic            is_imm;
  logic            use_imm;
  alu_op_e         op;
  logic            accept;
  logic            valid_q;
  id_ex_t          d;
  id_ex_t          q;

  assign opcode = Instr[6:0];
  assign rd     = Instr[11:7];
  assign f3     = Instr[14:12];
  assign rs1    = Instr[19:15];
  assign rs2    = Instr[24:20];
  assign f7     = Instr[31:25];
  assign imm    = {{(XLEN-12){Instr[31]}}, Instr[31:20]};
  assign is_op  = opcode == OPC_OP;
  assign is_imm = opcode == OPC_OPIMM;

  reg_file u_rf (
    .clk   (Clk),
    .reset (Reset),
    .ra1   (rs1),
    .ra2   (rs2),
    .we    (WbEn),
    .wa    (WbAddr),
    .wd    (WbData),
    .rd1   (rs1_val),
    .rd2   (rs2_val)
  );

  // Anything not explicitly matched falls through as ALU_ILLEGAL.
  always_comb begin
    op      = ALU_ILLEGAL;
    use_imm = 1'b0;
    unique case (1'b1)
      is_op: begin
        case (f3)
          3'b000: begin
            if (f7 == F7_BASE) op = ALU_ADD;
            else if (f7 == F7_ALT) op = ALU_SUB;
          end
          3'b101: begin
            if (f7 == F7_BASE) op = ALU_SRL;
            else if (f7 == F7_ALT) op = ALU_SRA;
          end
          3'b111: if (f7 == F7_BASE) op = ALU_AND;
          3'b110: if (f7 == F7_BASE) op = ALU_OR;
          3'b100: if (f7 == F7_BASE) op = ALU_XOR;
          3'b010: if (f7 == F7_BASE) op = ALU_SLT;
          3'b001: if (f7 == F7_BASE) op = ALU_SLL;
          default: ;
        endcase
      end
      is_imm: begin
        use_imm = 1'b1;
        case (f3)
          3'b000: op = ALU_ADD;
          3'b111: op = ALU_AND;
          3'b110: op = ALU_OR;
          3'b100: op = ALU_XOR;
          3'b010: op = ALU_SLT;
          3'b001: if (f7 == F7_BASE) op = ALU_SLL;
          3'b101: begin
            if (f7 == F7_BASE) op = ALU_SRL;
            else if (f7 == F7_ALT) op = ALU_SRA;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    d.op1       = rs1_val;
    d.op2       = use_imm ? imm : rs2_val;
    d.op        = op;
    d.rd        = rd;
    d.illegal   = op == ALU_ILLEGAL;
    d.reg_write = !d.illegal && rd != 5'd0;
  end

  assign InReady = !valid_q || OutReady;
  assign accept  = InValid && InReady;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      valid_q <= 1'b0;
      q       <= '0;
    end else if (Flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      q       <= d;
    end else if (OutReady) begin
      valid_q <= 1'b0;
    end
  end

  assign OutValid  = valid_q;
  assign Operand1  = q.op1;
  assign Operand2  = q.op2;
  assign Operation = q.op;
  assign Rd        = q.rd;
  assign RegWrite  = q.reg_write;
  assign Illegal   = q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed vector table, hand-written
// stall/flush/reset sequences, then randomized traffic vs a model.
module tb_decode_stage;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        InValid;
  logic        InReady;
  logic [31:0] Instr;
  logic        Flush;
  logic        WbEn;
  logic [4:0]  WbAddr;
  logic [31:0] WbData;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] Operand1;
  logic [31:0] Operand2;
  logic [3:0]  Operation;
  logic [4:0]  Rd;
  logic        RegWrite;
  logic        Illegal;

  int checks = 0;
  int errors = 0;

  decode_stage dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .InValid   (InValid),
    .InReady   (InReady),
    .Instr     (Instr),
    .Flush     (Flush),
    .WbEn      (WbEn),
    .WbAddr    (WbAddr),
    .WbData    (WbData),
    .OutValid  (OutValid),
    .OutReady  (OutReady),
    .Operand1  (Operand1),
    .Operand2  (Operand2),
    .Operation (Operation),
    .Rd        (Rd),
    .RegWrite  (RegWrite),
    .Illegal   (Illegal)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] instr;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        rw;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        rw;
    logic        ill;
  } exp_t;

  vec_t vecs[11];

  // Encoder tables: R-type {funct3, funct7, alu op}
  logic [2:0] r_f3[9] = '{3'b000, 3'b000, 3'b111, 3'b110, 3'b100,
                          3'b001, 3'b101, 3'b101, 3'b010};
  logic [6:0] r_f7[9] = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00,
                          7'h00, 7'h00, 7'h20, 7'h00};
  logic [3:0] r_op[9] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4,
                          4'd5, 4'd6, 4'd7, 4'd8};
  // I-type {funct3, fixed imm[11:5] flag, imm[11:5], alu op}
  logic [2:0] i_f3[8]  = '{3'b000, 3'b111, 3'b110, 3'b100, 3'b010,
                           3'b001, 3'b101, 3'b101};
  logic       i_fix[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                           1'b1, 1'b1, 1'b1};
  logic [6:0] i_hi[8]  = '{7'h00, 7'h00, 7'h00, 7'h00, 7'h00,
                           7'h00, 7'h00, 7'h20};
  logic [3:0] i_op[8]  = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd8,
                           4'd5, 4'd6, 4'd7};

  logic [31:0] m_regs[32];
  logic        mvalid;
  exp_t        mexp;
  exp_t        nexp;
  logic [31:0] instr_v;
  logic        acc;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  function automatic logic [31:0] rval(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (WbEn && WbAddr == r) return WbData;
    return m_regs[r];
  endfunction

  task automatic gen(output logic [31:0] ins, output exp_t e);
    int unsigned k;
    int unsigned sub;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [11:0] imm;
    logic [31:0] r;
    logic [6:0]  opc;
    logic [6:0]  f7;
    k   = $urandom_range(0, 19);
    rd  = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    r   = $urandom;
    imm = r[11:0];
    e.rd = rd;
    e.op1 = rval(rs1);
    if (k < 9) begin
      ins = {r_f7[k], rs2, rs1, r_f3[k], rd, 7'b0110011};
      e.op2 = rval(rs2);
      e.op  = r_op[k];
      e.ill = 1'b0;
    end else if (k < 17) begin
      if (i_fix[k-9]) imm[11:5] = i_hi[k-9];
      ins = {imm, rs1, i_f3[k-9], rd, 7'b0010011};
      e.op2 = {{20{imm[11]}}, imm};
      e.op  = i_op[k-9];
      e.ill = 1'b0;
    end else begin
      sub = $urandom_range(0, 2);
      r   = $urandom;
      opc = r[6:0];
      f7  = r[13:7] | 7'h01;
      if (opc == 7'b0110011 || opc == 7'b0010011) opc ^= 7'h40;
      if (sub == 0)
        ins = {imm, rs1, 3'b000, rd, opc};
      else if (sub == 1)
        ins = {imm, rs1, 3'b011, rd, r[14] ? 7'b0110011 : 7'b0010011};
      else
        ins = {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
      e.op2 = 32'd0;
      e.op  = 4'd15;
      e.ill = 1'b1;
    end
    e.rw = !e.ill && rd != 5'd0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{32'h002081B3, 1'b0, 5'd0, 32'd0,
                 32'd23, 32'd202, 4'd0, 5'd3, 1'b1, 1'b0};
    vecs[1]  = '{32'h40208233, 1'b0, 5'd0, 32'd0,
                 32'd23, 32'd202, 4'd1, 5'd4, 1'b1, 1'b0};
    vecs[2]  = '{32'hFFF00293, 1'b0, 5'd0, 32'd0,
                 32'd0, 32'hFFFFFFFF, 4'd0, 5'd5, 1'b1, 1'b0};
    vecs[3]  = '{32'h4040D313, 1'b1, 5'd1, 32'd99,
                 32'd99, 32'h00000404, 4'd7, 5'd6, 1'b1, 1'b0};
    vecs[4]  = '{32'h0020B1B3, 1'b0, 5'd0, 32'd0,
                 32'd0, 32'd0, 4'd15, 5'd3, 1'b0, 1'b1};
    vecs[5]  = '{32'h0000A183, 1'b0, 5'd0, 32'd0,
                 32'd0, 32'd0, 4'd15, 5'd3, 1'b0, 1'b1};
    vecs[6]  = '{32'h00208033, 1'b0, 5'd0, 32'd0,
                 32'd99, 32'd202, 4'd0, 5'd0, 1'b0, 1'b0};
    vecs[7]  = '{32'h001123B3, 1'b0, 5'd0, 32'd0,
                 32'd202, 32'd99, 4'd8, 5'd7, 1'b1, 1'b0};
    vecs[8]  = '{32'h022081B3, 1'b0, 5'd0, 32'd0,
                 32'd0, 32'd0, 4'd15, 5'd3, 1'b0, 1'b1};
    vecs[9]  = '{32'h00311413, 1'b0, 5'd0, 32'd0,
                 32'd202, 32'd3, 4'd5, 5'd8, 1'b1, 1'b0};
    vecs[10] = '{32'h40311413, 1'b0, 5'd0, 32'd0,
                 32'd0, 32'd0, 4'd15, 5'd8, 1'b0, 1'b1};

    Reset = 1'b1; InValid = 1'b0; Instr = 32'd0; Flush = 1'b0;
    WbEn = 1'b0; WbAddr = 5'd0; WbData = 32'd0; OutReady = 1'b1;
    step();
    step();
    Reset = 1'b0;
    #1;
    chk("rst_valid", 32'(OutValid), 32'd0);
    chk("rst_op1", Operand1, 32'd0);
    chk("rst_op2", Operand2, 32'd0);
    chk("rst_op", 32'(Operation), 32'd0);
    chk("rst_in_ready", 32'(InReady), 32'd1);

    WbEn = 1'b1; WbAddr = 5'd1; WbData = 32'd23;
    step();
    WbAddr = 5'd2; WbData = 32'd202;
    step();
    WbEn = 1'b0;

    for (int i = 0; i < 11; i++) begin
      Instr = vecs[i].instr; InValid = 1'b1; OutReady = 1'b1;
      WbEn = vecs[i].wb_en; WbAddr = vecs[i].wb_addr;
      WbData = vecs[i].wb_data;
      step();
      InValid = 1'b0; WbEn = 1'b0;
      chk($sformatf("vec%0d_valid", i), 32'(OutValid), 32'd1);
      chk($sformatf("vec%0d_op", i), 32'(Operation), 32'(vecs[i].op));
      chk($sformatf("vec%0d_rw", i), 32'(RegWrite), 32'(vecs[i].rw));
      chk($sformatf("vec%0d_ill", i), 32'(Illegal), 32'(vecs[i].ill));
      if (!vecs[i].ill) begin
        chk($sformatf("vec%0d_op1", i), Operand1, vecs[i].op1);
        chk($sformatf("vec%0d_op2", i), Operand2, vecs[i].op2);
        chk($sformatf("vec%0d_rd", i), 32'(Rd), 32'(vecs[i].rd));
      end
    end

    // Stall: hold OutReady low with a pending instruction.
    Instr = 32'h002081B3; InValid = 1'b1; OutReady = 1'b1;
    step();
    Instr = 32'h40208233; OutReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_in_ready", 32'(InReady), 32'd0);
      step();
      chk("stall_valid", 32'(OutValid), 32'd1);
      chk("stall_op", 32'(Operation), 32'd0);
      chk("stall_rd", 32'(Rd), 32'd3);
      chk("stall_op1", Operand1, 32'd99);
    end
    OutReady = 1'b1;
    #1;
    chk("unstall_in_ready", 32'(InReady), 32'd1);
    step();
    InValid = 1'b0;
    chk("unstall_valid", 32'(OutValid), 32'd1);
    chk("unstall_op", 32'(Operation), 32'd1);
    chk("unstall_rd", 32'(Rd), 32'd4);
    step();
    chk("drain_valid", 32'(OutValid), 32'd0);

    // Flush discards the held and the newly accepted instruction.
    Instr = 32'h002081B3; InValid = 1'b1;
    step();
    chk("pre_flush_valid", 32'(OutValid), 32'd1);
    Instr = 32'h40208233; Flush = 1'b1;
    step();
    Flush = 1'b0; InValid = 1'b0;
    chk("flush_valid", 32'(OutValid), 32'd0);

    // Reset while stalled.
    Instr = 32'h002081B3; InValid = 1'b1; OutReady = 1'b1;
    step();
    OutReady = 1'b0;
    step();
    Reset = 1'b1;
    step();
    Reset = 1'b0; InValid = 1'b0; OutReady = 1'b1;
    chk("rst2_valid", 32'(OutValid), 32'd0);
    chk("rst2_op1", Operand1, 32'd0);
    chk("rst2_op2", Operand2, 32'd0);
    chk("rst2_op", 32'(Operation), 32'd0);
    chk("rst2_rd", 32'(Rd), 32'd0);
    chk("rst2_rw", 32'(RegWrite), 32'd0);
    chk("rst2_ill", 32'(Illegal), 32'd0);
    Instr = 32'h000081B3; InValid = 1'b1;
    step();
    InValid = 1'b0;
    chk("rst2_x1_valid", 32'(OutValid), 32'd1);
    chk("rst2_x1_zero", Operand1, 32'd0);
    step();

    // Randomized traffic against the model.
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    mvalid = 1'b0;
    mexp = '{32'd0, 32'd0, 4'd0, 5'd0, 1'b0, 1'b0};
    for (int c = 0; c < 600; c++) begin
      chk("rnd_valid", 32'(OutValid), 32'(mvalid));
      if (mvalid) begin
        chk("rnd_op", 32'(Operation), 32'(mexp.op));
        chk("rnd_rw", 32'(RegWrite), 32'(mexp.rw));
        chk("rnd_ill", 32'(Illegal), 32'(mexp.ill));
        if (!mexp.ill) begin
          chk("rnd_op1", Operand1, mexp.op1);
          chk("rnd_op2", Operand2, mexp.op2);
          chk("rnd_rd", 32'(Rd), 32'(mexp.rd));
        end
      end
      InValid  = $urandom_range(0, 3) != 0;
      OutReady = $urandom_range(0, 2) != 0;
      Flush    = $urandom_range(0, 19) == 0;
      WbEn     = 1'($urandom_range(0, 1));
      WbAddr   = 5'($urandom_range(0, 7));
      WbData   = $urandom;
      gen(instr_v, nexp);
      Instr = instr_v;
      #1;
      chk("rnd_in_ready", 32'(InReady), 32'(!mvalid || OutReady));
      acc = InValid && (!mvalid || OutReady);
      if (Flush) mvalid = 1'b0;
      else if (acc) begin
        mvalid = 1'b1;
        mexp = nexp;
      end else if (OutReady) mvalid = 1'b0;
      if (WbEn && WbAddr != 5'd0) m_regs[WbAddr] = WbData;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
